// File: rtl/doy_pkg.sv
// doy_pkg: shared state encodings, day limits and the day-advance helper
package doy_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_ERR = 2'd2} state_t;
  localparam logic [6:0] LAST_NORM = 7'd120;
  localparam logic [6:0] LAST_LEAP = 7'd121;
  // >= rather than == so a 121 left over after a leap drop still wraps
  function automatic logic [6:0] next_day(input logic [6:0] d, input logic [6:0] last);
    return (d >= last) ? 7'd1 : d + 7'd1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled cycles and pulses tick on every TICK_DIV-th one
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == DIV_W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/day_of_year_sequencer.sv
// day_of_year_sequencer: day-of-year counter with load, single-step, auto-run and leap clamp
module day_of_year_sequencer import doy_pkg::*; #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] load_val,
  input  logic       leap,
  input  logic       load,
  input  logic       step,
  input  logic       run,
  output logic [6:0] data,
  output logic       leap_out,
  output logic       running,
  output logic       err,
  output logic       upd,
  output logic       wrap
);
  state_t state, state_n;
  logic load_q, step_q, leap_q, tick, load_e, step_e, legal, adv, clamp, clr, upd_n, wrap_n;
  logic [6:0] last, data_n;
  assign running = state == ST_RUN;
  assign err = state == ST_ERR;
  tick_prescaler #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_pre (
    .clk(CLOCK_50), .rst(reset), .en(running), .clr(clr), .tick(tick)
  );
  always_comb begin
    last = leap_out ? LAST_LEAP : LAST_NORM;
    load_e = load & ~load_q;
    step_e = step & ~step_q;
    legal = load_val != '0 && load_val <= last;
    adv = !err && (step_e || (tick && run));
    clamp = !err && leap_q && !leap_out && data == LAST_LEAP;
    clr = !running || load_e || step_e;
    state_n = load_e ? (legal ? (run ? ST_RUN : ST_IDLE) : ST_ERR) :
              err ? ST_ERR : run ? ST_RUN : ST_IDLE;
    data_n = load_e ? (legal ? load_val : data) :
             adv ? next_day(data, last) : clamp ? LAST_NORM : data;
    upd_n = load_e ? legal : adv || clamp;
    wrap_n = !load_e && adv && data >= last;
  end
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      state <= ST_IDLE;
      data <= 7'd1;
      leap_out <= 1'b0;
      leap_q <= 1'b0;
      load_q <= 1'b0;
      step_q <= 1'b0;
      upd <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      data <= data_n;
      leap_out <= leap;
      leap_q <= leap_out;
      load_q <= load;
      step_q <= step;
      upd <= upd_n;
      wrap <= wrap_n;
    end
endmodule
